adder_word_sequencer: RTL and testbench
=======================================

# adder_word_sequencer

Multi-byte add/subtract sequencer wrapped around the team's 8-bit combinational adder `behavioral` (F[7:0], G[7:0], Cin → S[8:0]). It accepts one wide operand pair per valid/ready handshake and drives the adder one byte per cycle, LSB first. Each cycle it registers S[8] as the next Cin and collects the S[7:0] bytes into a wide result, which it presents on a valid/ready output port. It sits directly upstream of the adder as its only driver and directly downstream as its only consumer.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 1–16. Operand width W = 8*NBYTES.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept an operand pair
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry-in for add, borrow-in for subtract
- op_sub  in  1  0 = a+b+cin; 1 = a−b−cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  W  result
- cout  out  1  carry out of the top byte (for subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready.
- Accept: an operand pair is accepted when in_valid && in_ready. On acceptance the block latches:
  - a_r = a
  - b_r = op_sub ? ~b : b
  - carry_r = op_sub ? ~cin : cin
  - op_sub
  - idx = 0
  - next state = RUN
- RUN, each cycle:
  - Adder inputs: F = a_r[8*idx +: 8], G = b_r[8*idx +: 8], Cin = carry_r.
  - Register sum_r[8*idx +: 8] = S[7:0] and carry_r = S[8].
  - If idx == NBYTES−1: register cout = S[8], compute ovf, go to DONE. Otherwise idx increments.
- Overflow: ovf = (a_r[W−1] == b_r[W−1]) && (sum_r[W−1] != a_r[W−1]). b_r here is the inverted operand in subtract mode. ovf uses the final top-byte result.
- DONE: out_valid = 1. sum, cout and ovf hold stable until out_valid && out_ready.
  - On that handshake the next state is IDLE, or RUN if a new pair is accepted in the same cycle (back-to-back).
- Outputs sum, cout and ovf come from registers only and change only on the final RUN cycle.
- No interaction with any other adder instance. The adder sees constant zero inputs in IDLE and DONE.
- Arithmetic is modulo 2^W. cout is the carry out of bit W−1.
- idx width is max(1, clog2(NBYTES)). With NBYTES=1, RUN lasts exactly one cycle.

## Timing
- Reset values: state IDLE, out_valid 0, sum 0, cout 0, ovf 0, idx 0, carry_r 0. in_ready reads 1 while rst_n is low.
- Reset is asynchronous at any point, including mid-RUN or in DONE with the result not yet consumed. The operation is discarded with no partial result visible, and the first accept after release behaves normally.
- Latency: acceptance at edge t gives out_valid high from edge t+NBYTES.
- Throughput: one operation per NBYTES+1 cycles with out_ready held high (accept in the DONE cycle).
- in_valid during RUN is ignored (in_ready=0). The upstream must hold a and b stable until accepted.
- Combinational path: adder delay from a_r, b_r and carry_r to sum_r/carry_r within one cycle. There is no path from any input port to any output port except out_ready → in_ready.

## Structure
- Shared package `adder_pkg`: state enum (IDLE, RUN, DONE), BYTE_W = 8, function for the idx width.
- One sub-module instance: `behavioral` (the 8-bit adder). It is instantiated once and not duplicated per byte.

## Test plan
- NBYTES=4, add, a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 edges after accept.
- Add, a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0 (carry ripples through all bytes).
- Add, a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1.
- Subtract, a=0x00000005, b=0x00000007, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. Subtract, a=0x80000000, b=1 → sum=0x7FFFFFFF, ovf=1.
- Backpressure: result in DONE, out_ready low for 3 cycles while in_valid presents a new pair.
  - sum stays stable and in_ready stays 0.
  - When out_ready rises, the result handshake and the new acceptance occur on the same edge, and the second result is correct.
- Reset: rst_n pulsed low during RUN at idx=2.
  - out_valid=0, sum=0, in_ready=1 immediately.
  - The next operation (a=3, b=4, add) gives sum=7.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Byte index width; a single-byte sequencer still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_word_sequencer_if.sv
// Operand/result handshake bundle between the sequencer and its upstream/downstream.
interface adder_word_sequencer_if
    import adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = BYTE_W * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/behavioral.sv
// 8-bit combinational adder: S = F + G + Cin, S[8] is the carry out.
module behavioral (
    input  logic [7:0] F,
    input  logic [7:0] G,
    input  logic       Cin,
    output logic [8:0] S
);

    assign S = {1'b0, F} + {1'b0, G} + {8'b0, Cin};

endmodule

// File: rtl/adder_word_sequencer.sv
// Wide add/subtract built by stepping a single 8-bit adder over the operands, LSB first.
module adder_word_sequencer
    import adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_word_sequencer_if.slave bus
);

    localparam int unsigned W  = BYTE_W * NBYTES;
    localparam int unsigned IW = idx_width(NBYTES);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [W-1:0]   a_q, b_q, acc_q, acc_d, sum_q;
    logic           carry_q, cout_q, ovf_q;

    logic           accept, last, run;
    logic [7:0]     f, g;
    logic           c_in;
    logic [8:0]     s;
    logic           ovf_d;

    assign run    = (state_q == RUN);
    assign last   = (idx_q == IW'(NBYTES - 1));
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Adder is held at zero outside RUN.
    assign f    = run ? a_q[BYTE_W*idx_q +: BYTE_W] : '0;
    assign g    = run ? b_q[BYTE_W*idx_q +: BYTE_W] : '0;
    assign c_in = run ? carry_q : 1'b0;

    behavioral u_adder (
        .F   (f),
        .G   (g),
        .Cin (c_in),
        .S   (s)
    );

    always_comb begin
        acc_d = acc_q;
        acc_d[BYTE_W*idx_q +: BYTE_W] = s[7:0];
    end

    // b_q already holds ~b when subtracting, so this covers both modes.
    assign ovf_d = (a_q[W-1] == b_q[W-1]) && (s[7] != a_q[W-1]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.op_sub ? ~bus.b : bus.b;
            carry_q <= bus.op_sub ^ bus.cin;
            idx_q   <= '0;
        end else if (run) begin
            acc_q   <= acc_d;
            carry_q <= s[8];
            if (last) begin
                sum_q  <= acc_d;
                cout_q <= s[8];
                ovf_q  <= ovf_d;
                idx_q  <= '0;
            end else begin
                idx_q  <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Directed and random checks of the byte-serial sequencer against a wide-arithmetic model.
module tb_adder_word_sequencer;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_word_sequencer_if #(.NBYTES(NBYTES)) bus ();

    adder_word_sequencer #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, sum} from plain signed/unsigned wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic sub);
        logic [W:0]          ur;
        logic signed [W+1:0] sr;
        logic                co, ov;
        if (!sub) begin
            ur = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            co = ur[W];
            sr = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b})
                 + $signed({{(W+1){1'b0}}, c});
        end else begin
            ur = {1'b0, a} - {1'b0, b} - (W+1)'(c);
            co = ~ur[W];
            sr = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b})
                 - $signed({{(W+1){1'b0}}, c});
        end
        ov = !((sr[W+1:W-1] == 3'b000) || (sr[W+1:W-1] == 3'b111));
        return {co, ov, ur[W-1:0]};
    endfunction

    // Called at the negedge right after the accepting edge; out_ready must be high.
    task automatic wait_result(input logic [W+1:0] exp, input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(NBYTES));
        check({tag, ".sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
        check({tag, ".cout"}, 64'(bus.cout), 64'(exp[W+1]));
        check({tag, ".ovf"}, 64'(bus.ovf), 64'(exp[W]));
        @(posedge clk);
        @(negedge clk);
        check({tag, ".consumed"}, 64'(bus.out_valid), 64'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic sub, input string tag);
        @(negedge clk);
        bus.a         = a;
        bus.b         = b;
        bus.cin       = c;
        bus.op_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(model(a, b, c, sub), tag);
    endtask

    initial begin
        logic [W+1:0] exp_x;
        logic [W-1:0] ra, rb;
        int           n;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.in_ready", 64'(bus.in_ready), 64'(1));
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.sum", 64'(bus.sum), 64'(0));
        check("rst.cout", 64'(bus.cout), 64'(0));
        check("rst.ovf", 64'(bus.ovf), 64'(0));
        rst_n = 1'b1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "add_ff_1");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, "sub_neg");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "sub_ovf");
        run_op(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, "sub_borrow_in");
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, "add_cin");

        // Backpressure: result held while a new pair waits, then handshake and accept together.
        exp_x = model(32'h0102_0304, 32'h00FF_00FF, 1'b0, 1'b0);
        @(negedge clk);
        bus.a         = 32'h0102_0304;
        bus.b         = 32'h00FF_00FF;
        bus.cin       = 1'b0;
        bus.op_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a      = 32'hDEAD_BEEF;
        bus.b      = 32'h2152_4111;
        bus.cin    = 1'b1;
        bus.op_sub = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("bp.latency", 64'(n), 64'(NBYTES));
        check("bp.x_sum", 64'(bus.sum), 64'(exp_x[W-1:0]));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_valid", 64'(bus.out_valid), 64'(1));
            check("bp.hold_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp.hold_sum", 64'(bus.sum), 64'(exp_x[W-1:0]));
            check("bp.hold_cout", 64'(bus.cout), 64'(exp_x[W+1]));
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.in_ready_comb", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(model(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b1), "bp.y");

        // Asynchronous reset mid-operation at idx 2.
        @(negedge clk);
        bus.a         = 32'hAAAA_5555;
        bus.b         = 32'h1111_2222;
        bus.cin       = 1'b0;
        bus.op_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid.in_ready_run", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", 64'(bus.out_valid), 64'(0));
        check("mid.sum", 64'(bus.sum), 64'(0));
        check("mid.in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = ~ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
